// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side end of the CPU data-memory bus. It accepts one load or store
// at a time, models a fixed access latency of LATENCY cycles, then produces
// a single-cycle resp_valid pulse. While a request is pending, stall is held
// high so the hazard unit can freeze the pipeline.
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag word-misaligned
// addresses. A flagged store leaves memory untouched, and a flagged load
// returns zero. Without the macro, req_addr[1:0] is ignored and resp_err is
// tied low.

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    // Word index width. The wait counter must be at least one bit wide,
    // even when LATENCY is 1 or 2.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    // WAIT burns LATENCY-1 cycles: one cycle at cnt==CNT_INIT, down to cnt==0.
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Word storage. It is never reset.
    logic [31:0] mem [DEPTH];

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Request fields captured at acceptance.
    logic             we_q;
    logic             err_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;

    // Request decode.
    logic             accept;
    logic [IDX_W-1:0] req_idx;
    logic             req_misaligned;

    // Read-data register load control.
    logic             rd_load;
    logic             rd_err;
    logic [IDX_W-1:0] rd_idx;

    // Address bits that do not take part in word selection. Bits above the
    // index wrap, so they are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    assign req_idx = req_addr[2 +: IDX_W];
    assign accept  = (state == IDLE) && req_valid;

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_misaligned = |req_addr[1:0];
`else
    assign req_misaligned = 1'b0;
`endif

    // Response outputs. The stall signal is combinational from req_valid,
    // so the pipeline freezes in the same cycle that a request appears.
    assign resp_valid = (state == RESP);
    assign stall      = req_valid & ~resp_valid;

`ifdef DMEM_ALIGN_CHECK_EN
    assign resp_err = resp_valid & err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Next-state and latency counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Decide when the read-data register loads: on the edge that enters
    // RESP, for loads only. With LATENCY==1 that edge is the acceptance
    // edge itself, so the live request fields are used instead of the
    // latched copies.
    always_comb begin
        rd_load = 1'b0;
        rd_err  = err_q;
        rd_idx  = idx_q;
        if ((LATENCY == 1) && accept && !req_we) begin
            rd_load = 1'b1;
            rd_err  = req_misaligned;
            rd_idx  = req_idx;
        end else if ((state == WAIT) && (cnt == '0) && !we_q) begin
            rd_load = 1'b1;
        end
    end

    // FSM state and counter registers. An asynchronous reset abandons any
    // outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Control fields of the accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            we_q  <= req_we;
            err_q <= req_misaligned;
        end
    end

    // Data fields of the accepted request. These are not reset, because
    // they are only consumed after a fresh acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
        end
    end

    // Registered read data. It holds its value through stores and idle
    // cycles, and a flagged load returns zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
        end else if (rd_load) begin
            resp_rdata <= rd_err ? 32'h0 : mem[rd_idx];
        end
    end

    // Store commit on the edge that leaves RESP. A reset that coincides
    // with that edge discards the store.
    always_ff @(posedge clk) begin
        if ((state == RESP) && we_q && !err_q && !reset) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
